// File: rtl/z80_bus_master_pkg.sv
// Shared definitions for the Z80 bus master: cycle-type codes (bus defs set)
// and the T-state encoding used by the cycle sequencer.
`ifndef Z80_BUS_DEFS_VH
`define Z80_BUS_DEFS_VH
`define CYC_M1 2'b00
`define CYC_RD 2'b01
`define CYC_WR 2'b10
`endif

package z80_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5
    } tstate_e;

    // phase bit value: h0 is the CPU-clock-high half
    localparam logic PH_H0 = 1'b1;
    localparam logic PH_H1 = 1'b0;

    // last T-state of a machine cycle; T4 exists only for M1
    function automatic logic is_last_tstate(input tstate_e st, input logic [1:0] cyc);
        return (st == ST_T4) || ((st == ST_T3) && (cyc != `CYC_M1));
    endfunction

endpackage

// File: rtl/z80_bus_master_if.sv
// Request/response handshake plus Z80 bus pins of the bus master.
interface z80_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        cpu_clk;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [7:0]  din;
    logic        nmreq;
    logic        nrd;
    logic        nwr;
    logic        nm1;
    logic        nrfsh;
    logic        nwait;
    logic [6:0]  r_reg;

    modport master (
        input  req_valid, req_type, req_addr, req_wdata, din, nwait,
        output req_ready, rsp_valid, rsp_rdata, cpu_clk, addr, dout, dout_oe,
               nmreq, nrd, nwr, nm1, nrfsh, r_reg
    );

    modport slave (
        output req_valid, req_type, req_addr, req_wdata, din, nwait,
        input  req_ready, rsp_valid, rsp_rdata, cpu_clk, addr, dout, dout_oe,
               nmreq, nrd, nwr, nm1, nrfsh, r_reg
    );
endinterface

// File: rtl/z80_bus_master_refresh_ctr.sv
// z80_refresh_ctr: 7-bit refresh counter (Z80 R register), loads R_INIT on reset.
module z80_refresh_ctr
    import z80_bus_master_pkg::*;
#(
    parameter logic [6:0] R_INIT = 7'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [6:0] r_reg
);
    logic [6:0] r_q;
    logic [6:0] r_d;

    // advance once per completed M1; wraps 7F -> 00 by width
    always_comb begin
        r_d = r_q;
        if (inc) r_d = r_q + 7'd1;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) r_q <= R_INIT;
        else     r_q <= r_d;
    end

    assign r_reg = r_q;
endmodule

// File: rtl/z80_bus_master.sv
// z80_bus_master: T-state-accurate Z80 memory-cycle initiator on a 2x clock.
// Build macro Z80_BUS_MASTER_WAIT_EN enables nwait-driven Tw insertion.
//
// state | meaning
// IDLE  | no cycle; phase keeps toggling, request taken in h1
// T1    | address driven at h0, strobes assert at h1
// T2    | strobes held; nwait sampled on the h0->h1 edge
// TW    | inserted wait; strobes held, nwait resampled
// T3    | M1: fetch data at rise, switch to refresh; RD/WR: end at fall
// T4    | M1 only: refresh strobe second half
module z80_bus_master #(
    parameter logic [7:0] I_REG    = 8'h00,
    parameter logic [6:0] R_INIT   = 7'h00,
    parameter int         MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    z80_bus_master_if.master bus
);
    import z80_bus_master_pkg::*;

    localparam int                WCNT_W   = $clog2(MAX_WAIT + 2);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

    logic              ph_q, ph_d;
    tstate_e           st_q, st_d;
    logic [1:0]        cyc_q, cyc_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wait_q, wait_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              dout_oe_q, dout_oe_d;
    logic              nmreq_q, nmreq_d;
    logic              nrd_q, nrd_d;
    logic              nwr_q, nwr_d;
    logic              nm1_q, nm1_d;
    logic              nrfsh_q, nrfsh_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              r_inc;
    logic [6:0]        r_cur;
    logic              is_m1, is_wr, req_ready, accept, wait_req;

    assign is_m1     = (cyc_q == `CYC_M1);
    assign is_wr     = (cyc_q == `CYC_WR);
    assign req_ready = (ph_q == PH_H1) && ((st_q == ST_IDLE) || is_last_tstate(st_q, cyc_q));
    assign accept    = req_ready & bus.req_valid;

`ifdef Z80_BUS_MASTER_WAIT_EN
    // wait budget is a down-counter; zero means no further Tw allowed
    assign wait_req = ~bus.nwait & (wcnt_q != '0);
`else
    logic wait_unused;
    assign wait_req    = 1'b0;
    assign wait_unused = ^{bus.nwait, wcnt_q};
`endif

    // next state and registered bus levels, one half-T-state per clk
    always_comb begin
        ph_d        = ~ph_q;
        st_d        = st_q;
        cyc_d       = cyc_q;
        wdata_d     = wdata_q;
        wait_d      = 1'b0;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        dout_oe_d   = dout_oe_q;
        nmreq_d     = nmreq_q;
        nrd_d       = nrd_q;
        nwr_d       = nwr_q;
        nm1_d       = nm1_q;
        nrfsh_d     = nrfsh_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        r_inc       = 1'b0;

        if (ph_q == PH_H0) begin
            // h0 -> h1: mid-T-state events
            case (st_q)
                ST_T1: begin
                    nmreq_d = 1'b0;
                    nrd_d   = is_wr;
                    if (is_wr) begin
                        dout_d    = wdata_q;
                        dout_oe_d = 1'b1;
                    end
                end
                ST_T2: begin
                    if (is_wr) nwr_d = 1'b0;
                    wait_d = wait_req;
                end
                ST_TW: wait_d = wait_req;
                ST_T3: begin
                    if (is_m1) begin
                        nmreq_d = 1'b0;
                    end else begin
                        nmreq_d = 1'b1;
                        nrd_d   = 1'b1;
                        nwr_d   = 1'b1;
                        if (!is_wr) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = bus.din;
                        end
                    end
                end
                ST_T4:   nmreq_d = 1'b1;
                default: ;
            endcase
        end else begin
            // h1 -> h0: T-state boundary
            if (st_q == ST_T4) begin
                nrfsh_d = 1'b1;
                r_inc   = 1'b1;
            end
            case (st_q)
                ST_T1: st_d = ST_T2;
                ST_T2, ST_TW: begin
                    if (wait_q) begin
                        st_d   = ST_TW;
                        wcnt_d = wcnt_q - WCNT_W'(1);
                    end else begin
                        st_d = ST_T3;
                        if (is_m1) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = bus.din;
                            nmreq_d     = 1'b1;
                            nrd_d       = 1'b1;
                            nm1_d       = 1'b1;
                            nrfsh_d     = 1'b0;
                            addr_d      = {I_REG, 1'b0, r_cur};
                        end
                    end
                end
                ST_T3:   st_d = is_m1 ? ST_T4 : ST_IDLE;
                ST_T4:   st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
            if (st_d == ST_IDLE) dout_oe_d = 1'b0;
            if (accept) begin
                st_d      = ST_T1;
                cyc_d     = bus.req_type;
                wdata_d   = bus.req_wdata;
                addr_d    = bus.req_addr;
                nm1_d     = (bus.req_type != `CYC_M1);
                dout_oe_d = 1'b0;
                wcnt_d    = WCNT_MAX;
            end
        end
    end

    // state, phase and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= PH_H1;
            st_q        <= ST_IDLE;
            cyc_q       <= `CYC_RD;
            wdata_q     <= '0;
            wait_q      <= 1'b0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            dout_oe_q   <= 1'b0;
            nmreq_q     <= 1'b1;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            nm1_q       <= 1'b1;
            nrfsh_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ph_q        <= ph_d;
            st_q        <= st_d;
            cyc_q       <= cyc_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            nmreq_q     <= nmreq_d;
            nrd_q       <= nrd_d;
            nwr_q       <= nwr_d;
            nm1_q       <= nm1_d;
            nrfsh_q     <= nrfsh_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    z80_refresh_ctr #(.R_INIT(R_INIT)) u_refresh (
        .clk   (clk),
        .rst   (rst),
        .inc   (r_inc),
        .r_reg (r_cur)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.cpu_clk   = ph_q;
    assign bus.addr      = addr_q;
    assign bus.dout      = dout_q;
    assign bus.dout_oe   = dout_oe_q;
    assign bus.nmreq     = nmreq_q;
    assign bus.nrd       = nrd_q;
    assign bus.nwr       = nwr_q;
    assign bus.nm1       = nm1_q;
    assign bus.nrfsh     = nrfsh_q;
    assign bus.r_reg     = r_cur;
endmodule
